fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_arb_pkg.sv | 6 +
 rtl/fifo_wr_arb_rr_pick.sv | 16 +
 rtl/fifo_wr_arb.sv | 61 ++++++
 tb/tb_fifo_wr_arb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM state type and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;
  localparam int DATA_W_DEF = 128;
  localparam int BURST_MAX_DEF = 4;
endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick: round-robin winner, first set req bit searching upward from last+1 with wrap.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] winner
);
  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    winner = last;
    for (int i = N; i >= 1; i--)
      if (req[IW'((int'(last) + i) % N)]) winner = IW'((int'(last) + i) % N);
  end
endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter steering NUM_REQ writers onto one FIFO write port.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       fifo_wren,
  output logic [DATA_W-1:0]          fifo_wrdata,
  input  logic                       fifo_full,
  input  logic                       fifo_alm_full,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_MAX + 1);
  state_t state, nxt;
  logic [IW-1:0] last_gnt, winner;
  logic [CW-1:0] beat_cnt;
  logic granted, sel_valid, xfer, arb, done;
  rr_pick #(.N(NUM_REQ)) u_pick (.req(req_valid), .last(last_gnt), .winner(winner));
  assign granted = state == GRANT;
  assign sel_valid = req_valid[gnt_id];
  assign xfer = granted && sel_valid && !fifo_full;
  assign arb = state == IDLE && |req_valid && !fifo_full;
  assign done = granted && (!sel_valid || (xfer && (beat_cnt == CW'(BURST_MAX - 1) || fifo_alm_full)));
  assign req_ready = (granted && !fifo_full) ? NUM_REQ'(1) << gnt_id : '0;
  assign fifo_wren = xfer;
  assign fifo_wrdata = req_data[gnt_id*DATA_W +: DATA_W];
  assign gnt_valid = granted;
  always_comb begin
    nxt = arb ? GRANT
        : done ? ((fifo_full || fifo_alm_full) ? HOLD : IDLE)
        : (state == HOLD && !fifo_alm_full) ? IDLE
        : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  // The grant decision latches the winner and restarts the burst count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_id <= '0;
      last_gnt <= IW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      if (arb) begin
        gnt_id <= winner;
        beat_cnt <= '0;
      end else if (xfer) beat_cnt <= beat_cnt + 1'b1;
      if (done) last_gnt <= gnt_id;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: table, directed and random checks of fifo_wr_arb against a cycle reference model.
module tb_fifo_wr_arb;
  localparam int N = 4, DW = 128, BM = 4, IW = 2;
  logic clk = 0, reset = 1;
  logic [N-1:0] req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic fifo_full = 0, fifo_alm_full = 0;
  logic [N-1:0] req_ready;
  logic fifo_wren, gnt_valid;
  logic [DW-1:0] fifo_wrdata;
  logic [IW-1:0] gnt_id;

  fifo_wr_arb #(.NUM_REQ(N), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wren(fifo_wren), .fifo_wrdata(fifo_wrdata),
    .fifo_full(fifo_full), .fifo_alm_full(fifo_alm_full),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, beats_seen = 0;
  bit m_busy, m_hold;
  int m_owner, m_prev, m_beats;

  typedef struct {
    logic [N-1:0] v;
    bit f, a;
    logic [N-1:0] r;
    bit w, g;
    logic [IW-1:0] id;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_hold = 0; m_owner = 0; m_prev = N - 1; m_beats = 0;
  endtask

  function automatic int rr(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(m_prev + k) % N]) return (m_prev + k) % N;
    return 0;
  endfunction

  // One clock: drive inputs at the falling edge, check outputs, advance the model.
  task automatic step(input logic [N-1:0] v, input bit f, input bit a);
    logic [N-1:0] er;
    bit ew, fin;
    @(negedge clk);
    req_valid = v; fifo_full = f; fifo_alm_full = a;
    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
    #1;
    ew = m_busy && v[m_owner] && !f;
    er = (m_busy && !f) ? N'(1) << m_owner : '0;
    chk("ready", DW'(req_ready), DW'(er));
    chk("wren", DW'(fifo_wren), DW'(ew));
    if (ew) chk("wrdata", fifo_wrdata, req_data[m_owner*DW +: DW]);
    chk("gnt_valid", DW'(gnt_valid), DW'(m_busy));
    chk("gnt_id", DW'(gnt_id), DW'(m_owner));
    chk("no_write_when_full", DW'(fifo_wren && fifo_full), '0);
    if (fifo_wren) beats_seen++;
    if (m_busy) begin
      if (ew) m_beats++;
      fin = !v[m_owner] || (ew && (m_beats == BM || a));
      if (fin) begin
        m_prev = m_owner; m_busy = 0; m_hold = f || a;
      end
    end else if (m_hold) begin
      if (!a) m_hold = 0;
    end else if (|v && !f) begin
      m_owner = rr(v); m_busy = 1; m_beats = 0;
    end
  endtask

  // Asynchronous reset pulse landing mid-cycle; outputs must clear at once.
  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("rst_ready", DW'(req_ready), '0);
    chk("rst_wren", DW'(fifo_wren), '0);
    chk("rst_gnt_valid", DW'(gnt_valid), '0);
    chk("rst_gnt_id", DW'(gnt_id), '0);
    req_valid = '0; fifo_full = 0; fifo_alm_full = 0;
    m_reset();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    logic [N-1:0] rv;
    tbl[0] = '{4'b0101, 0, 0, 4'b0000, 0, 0, 2'd0};
    for (int i = 1; i <= 4; i++) tbl[i] = '{4'b0101, 0, 0, 4'b0001, 1, 1, 2'd0};
    tbl[5] = '{4'b0101, 0, 0, 4'b0000, 0, 0, 2'd0};
    for (int i = 6; i <= 9; i++) tbl[i] = '{4'b0101, 0, 0, 4'b0100, 1, 1, 2'd2};
    tbl[10] = '{4'b0101, 0, 0, 4'b0000, 0, 0, 2'd2};
    tbl[11] = '{4'b0101, 0, 0, 4'b0001, 1, 1, 2'd0};
    m_reset();
    #2;
    chk("init_ready", DW'(req_ready), '0);
    chk("init_wren", DW'(fifo_wren), '0);
    chk("init_gnt_valid", DW'(gnt_valid), '0);
    @(negedge clk);
    reset = 0;

    // Requesters 0 and 2 alternate in bursts of four with one arbitration cycle between.
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].f, tbl[i].a);
      chk("tbl_ready", DW'(req_ready), DW'(tbl[i].r));
      chk("tbl_wren", DW'(fifo_wren), DW'(tbl[i].w));
      chk("tbl_gnt_valid", DW'(gnt_valid), DW'(tbl[i].g));
      chk("tbl_gnt_id", DW'(gnt_id), DW'(tbl[i].id));
    end

    // Requester 1 drops after two beats; next pick starts after it.
    pulse_reset();
    beats_seen = 0;
    repeat (3) step(4'b0010, 0, 0);
    step(4'b0000, 0, 0);
    chk("drop_beats", DW'(beats_seen), DW'(2));
    step(4'b1111, 0, 0);
    step(4'b1111, 0, 0);
    chk("drop_next_gnt", DW'(gnt_id), DW'(2));

    // Full stall for three cycles at beat two, then two beats remain.
    pulse_reset();
    beats_seen = 0;
    repeat (3) step(4'b0001, 0, 0);
    repeat (3) begin
      step(4'b0001, 1, 0);
      chk("stall_ready", DW'(req_ready), '0);
      chk("stall_wren", DW'(fifo_wren), '0);
    end
    chk("stall_gnt_id", DW'(gnt_id), '0);
    repeat (2) step(4'b0001, 0, 0);
    chk("stall_beats", DW'(beats_seen), DW'(4));
    step(4'b0001, 0, 0);
    chk("stall_end", DW'(gnt_valid), '0);

    // Almost-full on a transfer parks the arbiter in HOLD.
    pulse_reset();
    beats_seen = 0;
    step(4'b0001, 0, 0);
    step(4'b0001, 0, 1);
    repeat (3) begin
      step(4'b0001, 0, 1);
      chk("hold_wren", DW'(fifo_wren), '0);
    end
    chk("hold_beats", DW'(beats_seen), DW'(1));
    step(4'b0001, 0, 0);
    step(4'b0001, 0, 0);
    chk("hold_idle", DW'(gnt_valid), '0);
    step(4'b0001, 0, 0);
    chk("hold_regrant", DW'(gnt_valid), DW'(1));

    // Reset in the middle of a burst, then fresh arbitration starts at requester 0.
    pulse_reset();
    step(4'b0000, 0, 0);
    step(4'b1000, 0, 0);
    step(4'b1000, 0, 0);
    step(4'b1000, 0, 0);
    pulse_reset();
    step(4'b1111, 0, 0);
    step(4'b1111, 0, 0);
    chk("post_reset_gnt", DW'(gnt_id), '0);

    rv = '0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      if ($urandom_range(0, 3) == 0) rv = N'($urandom_range(0, 15));
      step(rv, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
